// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready handshake, status flags and accumulator operand.
// Opcode {C,S}: logic ops (C=0) pass/and/or/not, arithmetic ops (C=1) add/sub/inc/dec.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             C,
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             acc_sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   F,
  output logic             zero,
  output logic             ovf
);
  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
  logic [WIDTH-1:0] acc_q, x;
  logic [WIDTH:0]   f_d, f_q;
  logic             ovf_d, ovf_q, zero_q, valid_q, accept;
  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = valid_q;
  assign F         = f_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  always_comb begin
    x = acc_sel ? acc_q : A;
    case ({C, S})
      3'b000:  f_d = {1'b0, x};
      3'b001:  f_d = {1'b0, x & B};
      3'b010:  f_d = {1'b0, x | B};
      3'b011:  f_d = {1'b0, ~x};
      3'b100:  f_d = {1'b0, x} + {1'b0, B};
      3'b101:  f_d = {1'b0, x} - {1'b0, B};
      3'b110:  f_d = {1'b0, x} + ONE;
      default: f_d = {1'b0, x} - ONE;
    endcase
    ovf_d = C && (S == 2'b00 ? (x[WIDTH-1] == B[WIDTH-1]) && (f_d[WIDTH-1] != x[WIDTH-1]) :
                  S == 2'b01 ? (x[WIDTH-1] != B[WIDTH-1]) && (f_d[WIDTH-1] != x[WIDTH-1]) :
                  S == 2'b10 ? x == {1'b0, {(WIDTH-1){1'b1}}} :
                               x == {1'b1, {(WIDTH-1){1'b0}}});
  end
  // acc_clr wins over the accept update, but the accepted op already used the old acc via x
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      f_q     <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        f_q     <= f_d;
        zero_q  <= f_d[WIDTH-1:0] == '0;
        ovf_q   <= ovf_d;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      if (acc_clr) acc_q <= '0;
      else if (accept) acc_q <= f_d[WIDTH-1:0];
    end
  end
endmodule
